// File: rtl/pair_printer.sv
// UART (8N1) printer for transformer character pairs: emits "lhs:rhs" followed
// by a space, or by CR LF on the last pair of a line. Holds exactly one pair.
module pair_printer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  input  logic       line_end,
  output logic       tx,
  output logic       busy,
  output logic [7:0] pair_count,
  output logic [7:0] line_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef struct packed {
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       line_end;
  } pair_t;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  pair_t         cap;
  logic [7:0]    cur_byte;
  logic          baud_done;
  logic          last_byte;

  assign baud_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == (cap.line_end ? 3'd4 : 3'd3));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  // byte_idx walks lhs, ':', rhs, then ' ' or CR LF
  always_comb begin
    cur_byte = 8'h20;
    case (byte_idx)
      3'd0:    cur_byte = cap.lhs;
      3'd1:    cur_byte = 8'h3A;
      3'd2:    cur_byte = cap.rhs;
      3'd3:    cur_byte = cap.line_end ? 8'h0D : 8'h20;
      3'd4:    cur_byte = 8'h0A;
      default: cur_byte = 8'h20;
    endcase
  end

  // tx is decoded from state so reset forces the idle level immediately
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      cap        <= '0;
      pair_count <= '0;
      line_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap      <= {lhs, rhs, line_end};
            state    <= START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (last_byte) begin
              state      <= IDLE;
              byte_idx   <= '0;
              pair_count <= pair_count + 8'd1;
              if (cap.line_end) line_count <= line_count + 8'd1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pair_printer.sv
// Randomized bench for pair_printer: a transaction-level model predicts the byte
// stream, frame start cycles, ready window and counters; a UART decoder checks tx.
module tb_pair_printer;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] lhs = '0, rhs = '0;
  logic       line_end = 1'b0;
  logic       in_ready, tx, busy;
  logic [7:0] pair_count, line_count;

  pair_printer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .line_end(line_end), .tx(tx), .busy(busy),
    .pair_count(pair_count), .line_count(line_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         st;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, free_edge = 0;
  bit   pend = 0, pend_le = 0;
  logic [7:0] exp_pair = '0, exp_line = '0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: a pair occupies the line for 10*C cycles per byte, first start bit right after accept
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        free_edge = cyc;
        pend = 0;
        exp_pair = '0;
        exp_line = '0;
      end else begin
        cyc++;
        if (pend && cyc == free_edge) begin
          exp_pair = exp_pair + 8'd1;
          if (pend_le) exp_line = exp_line + 8'd1;
          pend = 0;
        end
        if (in_valid && (cyc - 1) >= free_edge) begin
          logic [7:0] bytes[$];
          bytes = '{lhs, 8'h3A, rhs};
          if (line_end) begin
            bytes.push_back(8'h0D);
            bytes.push_back(8'h0A);
          end else begin
            bytes.push_back(8'h20);
          end
          foreach (bytes[i]) exp_q.push_back('{b: bytes[i], st: cyc + 10 * C * i});
          free_edge = cyc + 10 * C * bytes.size();
          pend = 1;
          pend_le = line_end;
        end
      end
    end
  end

  // UART decoder and per-cycle output checks
  bit         in_frame = 0;
  int         fstart = 0;
  logic [7:0] rx = '0;
  exp_t       cur = '{b: 8'h00, st: 0};
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        chk("rst_tx", tx, 1);
        chk("rst_ready", in_ready, 1);
      end else begin
        chk("ready", in_ready, cyc >= free_edge);
        chk("busy", busy, cyc < free_edge);
        chk("pair_count", pair_count, exp_pair);
        chk("line_count", line_count, exp_line);
        if (!in_frame) begin
          if (tx == 1'b0) begin
            in_frame = 1;
            fstart = cyc;
            if (exp_q.size() == 0) begin
              chk("spurious_frame", 1, 0);
              cur = '{b: 8'h00, st: cyc};
            end else begin
              cur = exp_q.pop_front();
              chk("frame_start", cyc, cur.st);
            end
          end
        end else if ((cyc - fstart) % C == C / 2) begin
          int k;
          k = (cyc - fstart) / C;
          if (k >= 1 && k <= 8) rx[k-1] = tx;
          else if (k == 9) begin
            chk("stop_bit", tx, 1);
            chk("byte", rx, cur.b);
            in_frame = 0;
          end
        end
      end
    end
  end

  task automatic drive(input logic [7:0] l, input logic [7:0] r, input logic le);
    lhs = l; rhs = r; line_end = le; in_valid = 1'b1;
  endtask

  // Waits for the handshake, then scrambles the inputs to prove they were captured
  task automatic wait_acc(input bit hold, output int waits);
    bit rdy;
    waits = 0;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!rdy && waits < 3000);
    if (!rdy) chk("accept_timeout", 0, 1);
    @(negedge clk);
    #1;
    lhs = 8'($urandom); rhs = 8'($urandom); line_end = 1'($urandom);
    in_valid = hold;
  endtask

  task automatic send(input logic [7:0] l, input logic [7:0] r, input logic le, input bit hold);
    int w;
    @(negedge clk);
    #1;
    drive(l, r, le);
    wait_acc(hold, w);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < free_edge && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cyc < free_edge) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int w;
    #1;
    chk("init_tx", tx, 1);
    chk("init_ready", in_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_pair", pair_count, 0);
    chk("init_line", line_count, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    send(8'h41, 8'h62, 1'b0, 1'b0);
    wait_idle();
    chk("dir_pair1", pair_count, 1);
    chk("dir_line1", line_count, 0);

    send(8'h41, 8'h62, 1'b1, 1'b0);
    wait_idle();
    chk("dir_pair2", pair_count, 2);
    chk("dir_line2", line_count, 1);

    // in_valid stays high across both pairs; the second waits for in_ready
    send(8'h00, 8'hFF, 1'b0, 1'b1);
    send(8'hFF, 8'h00, 1'b1, 1'b0);
    wait_idle();

    // reset in the middle of the first byte's data bits
    send(8'h55, 8'hAA, 1'b1, 1'b0);
    repeat (2 * C) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_pair", pair_count, 0);
    chk("rst_mid_line", line_count, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    drive(8'h7E, 8'h01, 1'b0);
    wait_acc(1'b0, w);
    chk("first_edge_accept", w, 1);
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    wait_idle();

    pulse_rst();
    for (int i = 0; i < 256; i++) send(8'($urandom), 8'($urandom), 1'b1, i < 255);
    wait_idle();
    chk("wrap_pair", pair_count, 0);
    chk("wrap_line", line_count, 0);
    send(8'h30, 8'h31, 1'b1, 1'b0);
    wait_idle();
    chk("after_wrap_pair", pair_count, 1);
    chk("after_wrap_line", line_count, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule

// File: doc/pair_printer.md
PAIR_PRINTER -- requirements
Module: pair_printer

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per UART bit; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 in_valid  input  1  lhs/rhs/line_end hold a valid character pair.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 lhs  input  8  input-side ASCII char, from the upstream transformer.
REQ-007 rhs  input  8  transformed ASCII char, from the upstream transformer.
REQ-008 line_end  input  1  pair is the last of its line.
REQ-009 tx  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-010 busy  output  1  a pair is being serialized.
REQ-011 pair_count  output  8  pairs fully transmitted, modulo 256.
REQ-012 line_count  output  8  line_end pairs fully transmitted, modulo 256.

Function
REQ-013 Handshake: pair accepted on a rising edge where in_valid=1 and in_ready=1; lhs, rhs and line_end are captured into internal registers at that edge.
REQ-014 in_ready SHALL be 1 only in state IDLE; no buffering beyond the one captured pair.
REQ-015 Byte sequence per pair: lhs, 0x3A (':'), rhs, then 0x20 (' ') if line_end=0, or 0x0D then 0x0A if line_end=1.
REQ-016 Byte frame: start bit 0, data bits d0..d7, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-017 tx drives the start bit of the first byte starting the cycle after acceptance.
REQ-018 Consecutive bytes of one pair are sent with no idle gap between them.
REQ-019 Total pair duration: 40*CLKS_PER_BIT cycles (line_end=0) or 50*CLKS_PER_BIT cycles (line_end=1).
REQ-020 FSM states: IDLE, START, DATA, STOP. Transitions:
- IDLE->START on accept.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->START when further bytes remain.
- STOP->IDLE after the final byte.
REQ-021 Counters: baud counter 0..CLKS_PER_BIT-1; bit index 0..7; byte index 0..4.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 pair_count increments by 1 on the final cycle of the last stop bit; 255 wraps to 0.
REQ-024 line_count increments on that same edge only if the captured line_end=1; 255 wraps to 0.
REQ-025 in_ready returns to 1 on the cycle after the last stop bit ends.
REQ-026 A second pair offered while busy is not accepted; in_valid and data may change freely while in_ready=0.
REQ-027 Input changes after acceptance SHALL NOT affect bytes in flight.
REQ-028 lhs/rhs values are transmitted verbatim, including 0x00 and 0xFF.

Reset
REQ-029 While rst=1, outputs SHALL immediately (asynchronously) take these values: tx=1, in_ready=1, busy=0, pair_count=0, line_count=0.
REQ-030 While rst=1, state SHALL be IDLE and all counters and capture registers SHALL be 0.
REQ-031 Reset mid-frame abandons the pair: no count increment, and no residual bytes after release.
REQ-032 A pair may be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Reset: assert rst during DATA of any byte -> tx=1, busy=0, in_ready=1 in the same cycle; counts=0.
REQ-034 CLKS_PER_BIT=4, lhs=0x41, rhs=0x62, line_end=0 -> decoded bytes 41 3A 62 20; IDLE after 160 cycles; pair_count=1, line_count=0.
REQ-035 CLKS_PER_BIT=4, lhs=0x41, rhs=0x62, line_end=1 -> bytes 41 3A 62 0D 0A; IDLE after 200 cycles; line_count=1.
REQ-036 in_valid held high with two pairs queued by the bench -> second pair accepted exactly on the cycle in_ready returns; in_ready=0 throughout the first pair; no gaps or corruption.
REQ-037 Change lhs/rhs on the cycle after acceptance -> transmitted bytes still equal the originally captured values.
REQ-038 Send 256 pairs with line_end=1 -> pair_count and line_count both wrap to 0; the 257th pair sets both to 1.
